// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, control width and FSM state type shared by alu_seq
package alu_seq_pkg;

  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] OP_ADD  = 4'd0;
  localparam logic [CTRL_W-1:0] OP_SUB  = 4'd1;
  localparam logic [CTRL_W-1:0] OP_AND  = 4'd2;
  localparam logic [CTRL_W-1:0] OP_XOR  = 4'd3;
  localparam logic [CTRL_W-1:0] OP_OR   = 4'd4;
  localparam logic [CTRL_W-1:0] OP_SLL  = 4'd5;
  localparam logic [CTRL_W-1:0] OP_SRL  = 4'd6;
  localparam logic [CTRL_W-1:0] OP_SLT  = 4'd7;
  localparam logic [CTRL_W-1:0] OP_SLTU = 4'd8;
  localparam logic [CTRL_W-1:0] OP_SRA  = 4'd9;
  localparam logic [CTRL_W-1:0] OP_MUL  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add multiplier, one bit per cycle (used under ALU_SEQ_MUL_EN)
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  // The product is taken from the accumulator's next value so the caller can
  // capture it on the same edge as the final iteration.
  assign acc_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(1));
  assign product = acc_d;

  // Load operands on start, then add-and-shift once per cycle until the counter expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= CW'(WIDTH);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshake; ALU_SEQ_MUL_EN enables iterative MUL
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [CTRL_W-1:0] control,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              carry_out,
  output logic              overflow,
  output logic              zero,
  output logic              err
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, err_q, err_d;
  logic             valid_q, valid_d;
  logic             accept, is_mul, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] b_eff, sra_res;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_err;

  assign shamt   = b[SHW-1:0];
  assign sra_res = $signed(a) >>> shamt;
  assign accept  = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  state_e state_q, state_d;
  logic   mul_busy;

  assign is_mul   = (control == OP_MUL);
  assign in_ready = !rst && (state_q == ST_IDLE) && (!valid_q || out_ready);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Enter MUL on an accepted multiply, leave on the multiplier's final iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
      ST_MUL:  if (mul_done || !mul_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
  assign in_ready = !rst && (!valid_q || out_ready);
`endif

  // Adder shared by ADD and SUB; SUB is a + ~b + 1.
  always_comb begin
    b_eff = (control == OP_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (control == OP_SUB)};
  end

  // Single-cycle operation decode; anything not listed is illegal.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (control)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_XOR:  alu_res = a ^ b;
      OP_OR:   alu_res = a | b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SRA:  alu_res = sra_res;
      default: alu_err = 1'b1;
    endcase
  end

  // Output register next-state: hold until consumed, replace on a new result.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    if (out_ready) valid_d = 1'b0;
    if (mul_done) begin
      valid_d  = 1'b1;
      result_d = mul_prod[WIDTH-1:0];
      carry_d  = 1'b0;
      ovf_d    = |mul_prod[2*WIDTH-1:WIDTH];
      err_d    = 1'b0;
    end else if (accept && !is_mul) begin
      valid_d  = 1'b1;
      result_d = alu_res;
      carry_d  = alu_c;
      ovf_d    = alu_v;
      err_d    = alu_err;
    end
    zero_d = (result_d == '0);
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (MUL checks under ALU_SEQ_MUL_EN)
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic         carry_out, overflow, zero, err;
  logic [W-1:0] a, b, result;
  logic [3:0]   control;
  int           n_cmp = 0;
  int           n_bad = 0;

  // {out_valid, result, carry_out, overflow, zero, err}
  logic [36:0]  obs;
  assign obs = {out_valid, result, carry_out, overflow, zero, err};

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] av;
    logic [31:0] bv;
    logic [36:0] exp;
  } vec_t;

  localparam int NV = 15;
  localparam vec_t VEC [NV] = '{
    '{OP_ADD,  32'hFFFFFFFF, 32'hFFFFFFFF, {1'b1, 32'hFFFFFFFE, 4'b1000}},
    '{OP_SUB,  32'h80000000, 32'h70000000, {1'b1, 32'h10000000, 4'b1100}},
    '{OP_SUB,  32'h00000001, 32'h00000001, {1'b1, 32'h00000000, 4'b1010}},
    '{OP_SRA,  32'hFFFFFFF0, 32'h00000004, {1'b1, 32'hFFFFFFFF, 4'b0000}},
    '{OP_SRL,  32'hFFFFFFF0, 32'h00000004, {1'b1, 32'h0FFFFFFF, 4'b0000}},
    '{OP_SLL,  32'hFFFFFFFF, 32'h0000001E, {1'b1, 32'hC0000000, 4'b0000}},
    '{OP_SLL,  32'h00000001, 32'h00000024, {1'b1, 32'h00000010, 4'b0000}},
    '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, {1'b1, 32'h00000001, 4'b0000}},
    '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, {1'b1, 32'h00000000, 4'b0010}},
    '{OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, {1'b1, 32'h00F000F0, 4'b0000}},
    '{OP_OR,   32'h0F0F0000, 32'h000000F0, {1'b1, 32'h0F0F00F0, 4'b0000}},
    '{OP_XOR,  32'h12345678, 32'hFFFFFFFF, {1'b1, 32'hEDCBA987, 4'b0000}},
    '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, {1'b1, 32'h80000000, 4'b0100}},
    '{OP_SUB,  32'h00000000, 32'h00000001, {1'b1, 32'hFFFFFFFF, 4'b0000}},
    '{4'd15,   32'h12345678, 32'h9ABCDEF0, {1'b1, 32'h00000000, 4'b0011}}
  };

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .err       (err)
  );

  task automatic drive(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    in_valid = 1'b1; control = op; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if (obs !== 37'h0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_hold got obs=%h rdy=%b want obs=0 rdy=0", obs, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++;
    if (obs !== 37'h0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release got obs=%h rdy=%b want obs=0 rdy=1", obs, in_ready);
    end
  endtask

  task automatic test_ops;
    for (int i = 0; i < NV; i++) begin
      drive(VEC[i].op, VEC[i].av, VEC[i].bv);
      n_cmp++;
      if (obs !== VEC[i].exp) begin
        n_bad++; $display("FAIL op_vec%0d got %h want %h", i, obs, VEC[i].exp);
      end
    end
`ifndef ALU_SEQ_MUL_EN
    drive(OP_MUL, 32'h00010003, 32'h00000005);
    n_cmp++;
    if (obs !== {1'b1, 32'h0, 4'b0011}) begin
      n_bad++; $display("FAIL mul_disabled_illegal got %h want %h", obs, {1'b1, 32'h0, 4'b0011});
    end
`endif
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; control = VEC[i].op; a = VEC[i].av; b = VEC[i].bv;
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== VEC[i].exp) begin
        n_bad++; $display("FAIL b2b_vec%0d got %h want %h", i, obs, VEC[i].exp);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [36:0] held;
    logic        stable;
    out_ready = 1'b0;
    drive(OP_AND, 32'hFFFFFFFF, 32'h00000000);
    held = {1'b1, 32'h0, 4'b0010};
    n_cmp++;
    if (obs !== held) begin
      n_bad++; $display("FAIL bp_and got %h want %h", obs, held);
    end
    @(negedge clk);
    in_valid = 1'b1; control = OP_XOR; a = 32'hAAAA5555; b = 32'hFFFF0000;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (obs !== held || in_ready !== 1'b0) stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_bad++; $display("FAIL bp_hold got obs=%h rdy=%b want obs=%h rdy=0", obs, in_ready, held);
    end
    @(negedge clk);
    out_ready = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_ready_on_consume got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (obs !== {1'b1, 32'h55555555, 4'b0000}) begin
      n_bad++; $display("FAIL bp_replace got %h want %h", obs, {1'b1, 32'h55555555, 4'b0000});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_clear got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(OP_ADD, 32'h2, 32'h3);
    #2 rst = 1'b1; #1;
    n_cmp++;
    if (obs !== 37'h0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_async got obs=%h rdy=%b want obs=0 rdy=0", obs, in_ready);
    end
    @(negedge clk); rst = 1'b0; out_ready = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_after got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic test_mul;
    int   n;
    logic ready_low;
    for (int t = 0; t < 2; t++) begin
      out_ready = 1'b1;
      if (t == 0) drive(OP_MUL, 32'h00010003, 32'h00000005);
      else        drive(OP_MUL, 32'hFFFFFFFF, 32'h00000002);
      n = 0; ready_low = 1'b1;
      while (!out_valid && n < 100) begin
        if (in_ready !== 1'b0) ready_low = 1'b0;
        @(posedge clk); #1;
        n++;
      end
      n_cmp++;
      if (n != 32 || ready_low !== 1'b1) begin
        n_bad++; $display("FAIL mul%0d_latency got %0d rdy_low=%b want 32 rdy_low=1", t, n, ready_low);
      end
      n_cmp++;
      if (t == 0 && obs !== {1'b1, 32'h0005000F, 4'b0000}) begin
        n_bad++; $display("FAIL mul0_result got %h want %h", obs, {1'b1, 32'h0005000F, 4'b0000});
      end else if (t == 1 && obs !== {1'b1, 32'hFFFFFFFE, 4'b0100}) begin
        n_bad++; $display("FAIL mul1_result got %h want %h", obs, {1'b1, 32'hFFFFFFFE, 4'b0100});
      end
    end
  endtask

  task automatic test_mul_reset;
    logic quiet;
    out_ready = 1'b1;
    drive(OP_MUL, 32'h00010003, 32'h00000005);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1; #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL mulrst_during got vld=%b rdy=%b want 0 0", out_valid, in_ready);
    end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL mulrst_idle got rdy=%b want 1", in_ready);
    end
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (quiet !== 1'b1) begin
      n_bad++; $display("FAIL mulrst_no_result got out_valid seen, want none");
    end
  endtask
`endif

  task automatic test_illegal;
    drive(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF);
    n_cmp++;
    if (obs !== {1'b1, 32'h0, 4'b0011}) begin
      n_bad++; $display("FAIL illegal15 got %h want %h", obs, {1'b1, 32'h0, 4'b0011});
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; control = '0;
    test_reset;
    test_ops;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
`ifdef ALU_SEQ_MUL_EN
    test_mul;
    test_mul_reset;
`endif
    test_illegal;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
